// File: rtl/par_accum.sv
// Multi-operand accumulator: sums groups of N parity-tagged operands and
// emits each sum as a parity-tagged word with a group error flag.
module par_accum #(
  parameter int W = 4,
  parameter int N = 3,
  parameter bit DROP_BAD = 1'b0,
  localparam int SW = W + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [W:0]    in_word,
  output logic          in_ready,
  output logic          out_valid,
  output logic [SW:0]   out_word,
  output logic          out_err,
  input  logic          out_ready,
  output logic [7:0]    err_cnt
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {ST_ACC = 1'b0, ST_DONE = 1'b1} state_t;

  function automatic logic word_odd(input logic [W:0] w);
    return ^w;
  endfunction

  function automatic logic sum_par(input logic [SW-1:0] s);
    return ^s;
  endfunction

  state_t          state_q, state_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [SW:0]     out_word_q, out_word_d;
  logic            out_err_q, out_err_d;
  logic            xfer_s, bad_s, keep_s;
  logic [SW-1:0]   sum_s;

  // Next-state: clear aborts everything but err_cnt; otherwise accept or drain.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    err_cnt_d   = err_cnt_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_err_d   = out_err_q;
    xfer_s      = in_valid && (state_q == ST_ACC);
    bad_s       = word_odd(in_word);
    keep_s      = xfer_s && ((DROP_BAD == 1'b0) || !bad_s);
    sum_s       = acc_q + SW'(in_word[W:1]);
    if (clear) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      flag_d      = 1'b0;
      out_valid_d = 1'b0;
      out_word_d  = '0;
      out_err_d   = 1'b0;
    end else begin
      if (xfer_s && bad_s && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
      case (state_q)
        ST_ACC: begin
          if (keep_s && (cnt_q == LAST)) begin
            out_word_d  = {sum_s, sum_par(sum_s)};
            out_err_d   = flag_q | bad_s;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
            acc_d       = '0;
            cnt_d       = '0;
            flag_d      = 1'b0;
          end else if (keep_s) begin
            acc_d  = sum_s;
            cnt_d  = cnt_q + CW'(1);
            flag_d = flag_q | bad_s;
          end else begin
            state_d = ST_ACC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d     = ST_ACC;
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            flag_d      = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      err_cnt_q   <= err_cnt_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_par_accum.sv
// Bench for par_accum: two instances (keep / drop bad operands) on shared inputs,
// directed scenarios plus randomized traffic against a group-level model.
module tb_par_accum;

  localparam int W = 4;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [4:0] in_word = 5'd0;
  logic out_ready = 1'b0;

  logic       ir   [2];
  logic       ov   [2];
  logic [6:0] ow   [2];
  logic       oerr [2];
  logic [7:0] ec   [2];

  int n_checks = 0;
  int n_fail = 0;

  // group-level reference model, index = DROP_BAD policy
  int m_sum [2], m_cnt [2], m_errs [2], m_osum [2];
  bit m_done [2], m_flag [2], m_ov [2], m_oerr [2];

  always #5 clk = ~clk;

  par_accum #(.W(W), .N(N), .DROP_BAD(1'b0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_word(in_word),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_word(ow[0]), .out_err(oerr[0]),
    .out_ready(out_ready), .err_cnt(ec[0]));

  par_accum #(.W(W), .N(N), .DROP_BAD(1'b1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_word(in_word),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_word(ow[1]), .out_err(oerr[1]),
    .out_ready(out_ready), .err_cnt(ec[1]));

  function automatic logic [6:0] exp_word(input int s);
    return 7'((s * 2) + ($countones(s) % 2));
  endfunction

  function automatic logic [4:0] mk_word(input int d, input bit bad);
    logic [3:0] dv;
    dv = 4'(d);
    return {dv, 1'(($countones(dv) % 2) ^ int'(bad))};
  endfunction

  task automatic model_edge();
    int d;
    bit bad;
    d = int'(in_word[4:1]);
    bad = ($countones(in_word) % 2) == 1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_errs[k] = 0; m_osum[k] = 0;
        m_done[k] = 0; m_flag[k] = 0; m_ov[k] = 0; m_oerr[k] = 0;
      end else if (clear) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_osum[k] = 0;
        m_done[k] = 0; m_flag[k] = 0; m_ov[k] = 0; m_oerr[k] = 0;
      end else if (!m_done[k]) begin
        if (in_valid) begin
          if (bad && m_errs[k] < 255) m_errs[k]++;
          if (k == 0 || !bad) begin
            m_sum[k] += d;
            m_cnt[k]++;
            m_flag[k] |= bad;
            if (m_cnt[k] == N) begin
              m_osum[k] = m_sum[k]; m_oerr[k] = m_flag[k]; m_ov[k] = 1;
              m_done[k] = 1; m_sum[k] = 0; m_cnt[k] = 0; m_flag[k] = 0;
            end
          end
        end
      end else if (out_ready) begin
        m_done[k] = 0; m_ov[k] = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] w);
    in_valid = 1'b1;
    in_word = w;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || ow[k] !== 7'd0 || oerr[k] !== 1'b0 || ec[k] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got ir=%b ov=%b ow=%b err=%b cnt=%0d, required 1 0 0 0 0",
                 k, ir[k], ov[k], ow[k], oerr[k], ec[k]);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    send(5'b11101);
    send(5'b00110);
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL basic_early: ov=%b ir=%b, required 0 1", ov[0], ir[0]);
    end
    send(5'b00101);
    in_valid = 1'b0;
    n_checks++;
    if (ov[0] !== 1'b1 || ow[0] !== 7'b0100111 || oerr[0] !== 1'b0 || ir[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: ov=%b ow=%b err=%b ir=%b, required 1 0100111 0 0", ov[0], ow[0], oerr[0], ir[0]);
    end
    tick();
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL basic_drain: ov=%b ir=%b, required 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_max();
    do_reset();
    repeat (3) send(5'b11110);
    in_valid = 1'b0;
    n_checks++;
    if (ov[0] !== 1'b1 || ow[0] !== 7'b1011010 || oerr[0] !== 1'b0) begin
      n_fail++; $display("FAIL max_sum: ov=%b ow=%b err=%b, required 1 1011010 0", ov[0], ow[0], oerr[0]);
    end
    tick();
  endtask

  task automatic test_bad_keep();
    do_reset();
    send(5'b11100);
    send(5'b00110);
    send(5'b00101);
    in_valid = 1'b0;
    n_checks++;
    if (ov[0] !== 1'b1 || ow[0] !== 7'b0100111 || oerr[0] !== 1'b1 || ec[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL bad_keep: ov=%b ow=%b err=%b cnt=%0d, required 1 0100111 1 1", ov[0], ow[0], oerr[0], ec[0]);
    end
    tick();
  endtask

  task automatic test_bad_drop();
    do_reset();
    send(5'b11100);
    send(5'b11101);
    send(5'b00110);
    n_checks++;
    if (ov[1] !== 1'b0) begin
      n_fail++; $display("FAIL drop_early: ov=%b, required 0", ov[1]);
    end
    send(5'b00101);
    in_valid = 1'b0;
    n_checks++;
    if (ov[1] !== 1'b1 || ow[1] !== 7'b0100111 || oerr[1] !== 1'b0 || ec[1] !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_result: ov=%b ow=%b err=%b cnt=%0d, required 1 0100111 0 1", ov[1], ow[1], oerr[1], ec[1]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int d [6];
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) d[i] = $urandom_range(0, 15);
    for (int i = 0; i < 3; i++) send(mk_word(d[i], 1'b0));
    in_word = mk_word(d[3], 1'b0);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (ov[0] !== 1'b1 || ow[0] !== exp_word(d[0] + d[1] + d[2]) || ir[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: ov=%b ow=%b ir=%b, required 1 %b 0", c, ov[0], ow[0], ir[0],
                 exp_word(d[0] + d[1] + d[2]));
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: ov=%b ir=%b, required 0 1", ov[0], ir[0]);
    end
    for (int i = 3; i < 6; i++) send(mk_word(d[i], 1'b0));
    in_valid = 1'b0;
    n_checks++;
    if (ov[0] !== 1'b1 || ow[0] !== exp_word(d[3] + d[4] + d[5])) begin
      n_fail++; $display("FAIL stall_next: ov=%b ow=%b, required 1 %b", ov[0], ow[0], exp_word(d[3] + d[4] + d[5]));
    end
    tick();
  endtask

  task automatic test_abort();
    int d [3];
    do_reset();
    send(mk_word(9, 1'b0));
    send(mk_word(7, 1'b0));
    clear = 1'b1;
    send(5'b11100);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) d[i] = $urandom_range(0, 15);
    for (int i = 0; i < 3; i++) send(mk_word(d[i], 1'b0));
    in_valid = 1'b0;
    n_checks++;
    if (ov[0] !== 1'b1 || ow[0] !== exp_word(d[0] + d[1] + d[2]) || ec[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_group: ov=%b ow=%b cnt=%0d, required 1 %b 0", ov[0], ow[0], ec[0], exp_word(d[0] + d[1] + d[2]));
    end
    tick();
    out_ready = 1'b0;
    send(5'b11100);
    send(mk_word(1, 1'b0));
    send(mk_word(2, 1'b0));
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || ec[0] !== 8'd1) begin
      n_fail++; $display("FAIL clear_done: ov=%b ir=%b cnt=%0d, required 0 1 1", ov[0], ir[0], ec[0]);
    end
    out_ready = 1'b1;
    send(5'b11100);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (ov[0] !== 1'b0 || ow[0] !== 7'd0 || oerr[0] !== 1'b0 || ec[0] !== 8'd0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: ov=%b ow=%b err=%b cnt=%0d ir=%b, required 0 0 0 0 1", ov[0], ow[0], oerr[0], ec[0], ir[0]);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (300) send(mk_word($urandom_range(0, 15), 1'b1));
    in_valid = 1'b0;
    n_checks++;
    if (ec[1] !== 8'd255 || ec[0] !== 8'(m_errs[0])) begin
      n_fail++; $display("FAIL saturate: cnt1=%0d cnt0=%0d, required 255 %0d", ec[1], ec[0], m_errs[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      clear = ($urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_word = mk_word($urandom_range(0, 15), $urandom_range(0, 4) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ov[k] !== m_ov[k] || ow[k] !== exp_word(m_osum[k]) || oerr[k] !== m_oerr[k] ||
            ec[k] !== 8'(m_errs[k]) || ir[k] !== !m_done[k]) begin
          n_fail++;
          $display("FAIL random[%0d] cyc %0d: ov=%b ow=%b err=%b cnt=%0d ir=%b, required %b %b %b %0d %b",
                   k, c, ov[k], ow[k], oerr[k], ec[k], ir[k], m_ov[k], exp_word(m_osum[k]),
                   m_oerr[k], m_errs[k], !m_done[k]);
        end
      end
    end
    clear = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_bad_keep();
    test_bad_drop();
    test_backpressure();
    test_abort();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/par_accum.md
# par_accum

Parametrised multi-operand accumulator with parity protection. It accepts a stream of parity-tagged W-bit operands over a valid/ready handshake and sums each group of N operands sequentially. Each completed sum is emitted as a parity-tagged word together with an error flag. It sits in the arithmetic datapath where operand words arrive already carrying the even-parity bit produced by the parity generator.

## Interface
- W, 4: operand data width in bits.
- N, 3: operands per group; legal range is N >= 2.
- DROP_BAD, 0: policy for an operand with bad parity.
  - 0: the operand is accumulated and counted, and the group error flag is set.
  - 1: the operand is discarded and not counted; the group waits for a replacement.
- SW (localparam), W + $clog2(N): sum width. It holds N*(2^W-1) without overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous abort of the current group; same effect as rst except err_cnt is retained.
- in_valid  in  1  operand present.
- in_word  in  W+1  operand as {data[W-1:0], p}. It is well-formed when the XOR of all W+1 bits is 0.
- in_ready  out  1  block can accept an operand.
- out_valid  out  1  result present.
- out_word  out  SW+1  result as {sum[SW-1:0], ^sum}.
- out_err  out  1  at least one bad-parity operand contributed to this group (DROP_BAD=0 only).
- out_ready  in  1  downstream accepts the result.
- err_cnt  out  8  total bad-parity operands seen; saturates at 255.

## Operation
- Two states: ACC (collecting operands) and DONE (holding a result).
- Reset: state=ACC, acc=0, cnt=0, err flag 0, err_cnt=0, out_valid=0, out_word=0, out_err=0. in_ready=1 from the first cycle after reset.
- in_ready = (state==ACC). A transfer occurs when in_valid && in_ready on a clock edge.
- Parity check on every transfer: bad = ^in_word.
- If bad, err_cnt increments, saturating at 255.
- Transfer with DROP_BAD=0, or with good parity:
  - acc += in_word[W:1], zero-extended to SW bits.
  - cnt += 1.
  - The error flag ORs in bad.
- Transfer with DROP_BAD=1 and bad parity: acc, cnt and the error flag are unchanged.
- Counted transfer when cnt==N-1:
  - out_word <= {acc+data, ^(acc+data)}.
  - out_err <= flag|bad.
  - out_valid <= 1, state <= DONE.
- DONE:
  - out_word and out_err are held stable while out_valid=1 && !out_ready.
  - On out_ready, the next state is ACC with out_valid=0, acc=0, cnt=0 and flag=0.
- clear, in any state:
  - Next state is ACC with acc=0, cnt=0, flag=0 and out_valid=0.
  - A pending result is dropped. err_cnt is unchanged.
  - A transfer presented in the same cycle as clear is ignored, including for err_cnt.
- rst has priority over clear; clear has priority over transfer and over out_ready.
- Arithmetic is unsigned and never wraps within a group.

## Timing
- out_valid rises on the edge after the Nth counted transfer; latency is 1 cycle.
- Minimum period per group is N+1 cycles: N accept cycles plus 1 DONE cycle with out_ready=1.
- in_ready drops on the same edge that out_valid rises, and returns on the edge that consumes the result.
- All outputs are registered except in_ready, which is decoded from the state register.
- in_valid may stay high across the DONE stall; the word is taken on the first cycle in_ready=1.

## Test plan
- Basic sum, W=4, N=3, DROP_BAD=0: send 11101, 00110, 00101 (data 14, 3, 2) back to back with out_ready=1. Required: out_valid pulses 1 cycle after the 3rd transfer; out_word=7'b0100111 (sum 19, parity 1); out_err=0; in_ready low exactly 1 cycle.
- Maximum value: send 11110 three times (data 15). Required: out_word=7'b1011010 (sum 45, parity 0); no overflow.
- Bad parity, DROP_BAD=0: send 11100, 00110, 00101. Required: sum 19 (out_word=7'b0100111), out_err=1, err_cnt=1.
- Bad parity, DROP_BAD=1: send 11100, 11101, 00110, 00101. Required: the result appears only after the 4th word; sum 19; out_err=0; err_cnt=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 throughout. Required: out_word stable, in_ready=0, no operand consumed; the next group starts the cycle after out_ready=1.
- Abort:
  - Assert clear after 2 transfers. Required: cnt resets and the next 3 words form a fresh group.
  - Assert clear in DONE. Required: out_valid=0 next cycle, err_cnt retained.
  - Assert rst mid-group. Required: all outputs at reset values, err_cnt=0.
